// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline control block and the rest of the core:
// redirect requests, hold requests, decode register reads, long-latency
// issue/complete events, and the resulting hold/redirect/status outputs.
interface hazard_ctrl_if;

  // Redirect requests
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;

  // Hold requests
  logic        hold_req_ex_i;
  logic        hold_req_rib_i;
  logic        hold_req_jtag_i;

  // Decode register reads
  logic        id_reg1_re_i;
  logic        id_reg2_re_i;
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;

  // Long-latency writeback tracking
  logic        lat_issue_i;
  logic [4:0]  lat_issue_waddr_i;
  logic        lat_done_i;
  logic [4:0]  lat_done_waddr_i;

  // Outputs
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [31:0] sb_pending_o;
  logic        stall_timeout_o;

  // Core / bench side: drives requests, observes control outputs
  modport master (
    output jump_flag_i, jump_addr_i, int_assert_i, int_addr_i,
    output hold_req_ex_i, hold_req_rib_i, hold_req_jtag_i,
    output id_reg1_re_i, id_reg2_re_i, id_reg1_raddr_i, id_reg2_raddr_i,
    output lat_issue_i, lat_issue_waddr_i, lat_done_i, lat_done_waddr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, sb_pending_o, stall_timeout_o
  );

  // Control block side
  modport slave (
    input  jump_flag_i, jump_addr_i, int_assert_i, int_addr_i,
    input  hold_req_ex_i, hold_req_rib_i, hold_req_jtag_i,
    input  id_reg1_re_i, id_reg2_re_i, id_reg1_raddr_i, id_reg2_raddr_i,
    input  lat_issue_i, lat_issue_waddr_i, lat_done_i, lat_done_waddr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, sb_pending_o, stall_timeout_o
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: merges hold requests into a single hold level,
// redirects the PC on jump/interrupt, tracks pending long-latency writebacks
// in a register scoreboard (RAW interlock), sequences post-redirect flushes
// and flags decode stalls that last too long.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 8
) (
  input  logic         clk,
  input  logic         rst,   // asynchronous, active low
  hazard_ctrl_if.slave bus
);

  // Hold levels; a larger value freezes more of the pipeline front end.
  // Level 3'b010 (hold if_id only) is never requested by this block.
  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]        sb_q, sb_d;
  logic               stall_timeout_q, stall_timeout_d;

  logic               redirect;
  logic               in_flush;
  logic               raw_hit;
  logic               raw_stall;

  // Redirect request and flush phase decode
  always_comb begin
    redirect = bus.jump_flag_i | bus.int_assert_i;
    in_flush = (state_q == ST_FLUSH);
  end

  // RAW interlock against the scoreboard; bit 0 is never set so x0 never stalls.
  // Suppressed while decode is being killed by a redirect or flush.
  always_comb begin
    raw_hit   = (bus.id_reg1_re_i & sb_q[bus.id_reg1_raddr_i]) |
                (bus.id_reg2_re_i & sb_q[bus.id_reg2_raddr_i]);
    raw_stall = raw_hit & ~redirect & ~in_flush;
  end

  // Hold merge and redirect outputs; forced idle while reset is asserted
  always_comb begin
    bus.hold_flag_o = HOLD_NONE;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = '0;
    if (rst) begin
      bus.jump_flag_o = redirect;
      if (bus.int_assert_i) begin
        bus.jump_addr_o = bus.int_addr_i;
      end else if (bus.jump_flag_i) begin
        bus.jump_addr_o = bus.jump_addr_i;
      end
      // Numeric maximum of the active levels: any Id source dominates Pc sources
      if (redirect | in_flush | bus.hold_req_ex_i | raw_stall) begin
        bus.hold_flag_o = HOLD_ID;
      end else if (bus.hold_req_rib_i | bus.hold_req_jtag_i) begin
        bus.hold_flag_o = HOLD_PC;
      end
    end
  end

  // Flush sequencer next state: each redirect (re)starts a FLUSH_CYCLES hold
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (redirect && (FLUSH_CYCLES != 0)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LD;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          flush_cnt_d = FLUSH_LD;
        end else if (flush_cnt_q == CNT_ONE) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Scoreboard next state: clear first, then set, so set wins on the same rd
  always_comb begin
    sb_d = sb_q;
    if (bus.lat_done_i) begin
      sb_d[bus.lat_done_waddr_i] = 1'b0;
    end
    if (bus.lat_issue_i && (bus.lat_issue_waddr_i != 5'd0)) begin
      sb_d[bus.lat_issue_waddr_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Stall watchdog: run length of consecutive RAW stalls, sticky timeout flag
  always_comb begin
    stall_cnt_d     = '0;
    stall_timeout_d = stall_timeout_q;
    if (raw_stall) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
    end
    if (stall_cnt_d >= STALL_LIM) begin
      stall_timeout_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_RUN;
      flush_cnt_q     <= '0;
      stall_cnt_q     <= '0;
      sb_q            <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      sb_q            <= sb_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // Registered status outputs
  always_comb begin
    bus.sb_pending_o    = sb_q;
    bus.stall_timeout_o = stall_timeout_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances with different flush/timeout settings
// share one stimulus stream and are compared every cycle against a
// cycle-level behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        jf, ia, ex, rib, jtag, r1e, r2e, li, ld;
  logic [31:0] ja, iaddr;
  logic [4:0]  a1, a2, lw, dw;

  hazard_ctrl_if bus0();
  hazard_ctrl_if bus1();

  assign bus0.jump_flag_i = jf;       assign bus1.jump_flag_i = jf;
  assign bus0.jump_addr_i = ja;       assign bus1.jump_addr_i = ja;
  assign bus0.int_assert_i = ia;      assign bus1.int_assert_i = ia;
  assign bus0.int_addr_i = iaddr;     assign bus1.int_addr_i = iaddr;
  assign bus0.hold_req_ex_i = ex;     assign bus1.hold_req_ex_i = ex;
  assign bus0.hold_req_rib_i = rib;   assign bus1.hold_req_rib_i = rib;
  assign bus0.hold_req_jtag_i = jtag; assign bus1.hold_req_jtag_i = jtag;
  assign bus0.id_reg1_re_i = r1e;     assign bus1.id_reg1_re_i = r1e;
  assign bus0.id_reg2_re_i = r2e;     assign bus1.id_reg2_re_i = r2e;
  assign bus0.id_reg1_raddr_i = a1;   assign bus1.id_reg1_raddr_i = a1;
  assign bus0.id_reg2_raddr_i = a2;   assign bus1.id_reg2_raddr_i = a2;
  assign bus0.lat_issue_i = li;       assign bus1.lat_issue_i = li;
  assign bus0.lat_issue_waddr_i = lw; assign bus1.lat_issue_waddr_i = lw;
  assign bus0.lat_done_i = ld;        assign bus1.lat_done_i = ld;
  assign bus0.lat_done_waddr_i = dw;  assign bus1.lat_done_waddr_i = dw;

  hazard_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  hazard_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(6), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Model: pending registers, remaining flush cycles, stall run length, timeout
  int unsigned FC [2] = '{1, 3};
  int unsigned TO [2] = '{4, 6};
  bit          m_sb [32];
  int unsigned m_fl [2];
  int unsigned m_run [2];
  bit          m_to [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    jf = 0; ja = '0; ia = 0; iaddr = '0; ex = 0; rib = 0; jtag = 0;
    r1e = 0; r2e = 0; a1 = '0; a2 = '0; li = 0; lw = '0; ld = 0; dw = '0;
  endtask

  task automatic model_reset();
    foreach (m_sb[i]) m_sb[i] = 0;
    for (int k = 0; k < 2; k++) begin
      m_fl[k] = 0; m_run[k] = 0; m_to[k] = 0;
    end
  endtask

  // Called at a falling edge with inputs set; checks then advances the model
  task automatic step();
    bit          redir, inflush, raw;
    logic [2:0]  ehold [2];
    bit          eraw [2];
    logic [31:0] eaddr, esb;
    #1;
    redir = jf | ia;
    eaddr = ia ? iaddr : (jf ? ja : 32'd0);
    esb = '0;
    for (int i = 1; i < 32; i++) esb[i] = m_sb[i];
    for (int k = 0; k < 2; k++) begin
      inflush = (m_fl[k] > 0);
      raw = !redir && !inflush &&
            ((r1e && a1 != 0 && m_sb[a1]) || (r2e && a2 != 0 && m_sb[a2]));
      eraw[k] = raw;
      if (redir || inflush || ex || raw) ehold[k] = 3'd3;
      else if (rib || jtag)              ehold[k] = 3'd1;
      else                               ehold[k] = 3'd0;
    end
    check("hold0", 32'(bus0.hold_flag_o), 32'(ehold[0]));
    check("hold1", 32'(bus1.hold_flag_o), 32'(ehold[1]));
    check("jflag0", 32'(bus0.jump_flag_o), 32'(redir));
    check("jflag1", 32'(bus1.jump_flag_o), 32'(redir));
    check("jaddr0", bus0.jump_addr_o, eaddr);
    check("sb0", bus0.sb_pending_o, esb);
    check("sb1", bus1.sb_pending_o, esb);
    check("tmo0", 32'(bus0.stall_timeout_o), 32'(m_to[0]));
    check("tmo1", 32'(bus1.stall_timeout_o), 32'(m_to[1]));
    for (int k = 0; k < 2; k++) begin
      if (redir) m_fl[k] = FC[k];
      else if (m_fl[k] > 0) m_fl[k]--;
      m_run[k] = eraw[k] ? ((m_run[k] < 255) ? m_run[k] + 1 : 255) : 0;
      if (m_run[k] >= TO[k]) m_to[k] = 1;
    end
    if (ld && dw != 0) m_sb[dw] = 0;
    if (li && lw != 0) m_sb[lw] = 1;
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of a cycle, released on a falling edge
  task automatic do_reset();
    idle();
    #2 rst = 0;
    #1;
    check("rst_hold0", 32'(bus0.hold_flag_o), 32'd0);
    check("rst_hold1", 32'(bus1.hold_flag_o), 32'd0);
    check("rst_jflag", 32'(bus0.jump_flag_o), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic raw_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      idle(); r1e = 1; a1 = 5'd7; step();
    end
  endtask

  initial begin
    idle();
    model_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;

    // Reset during FLUSH with a pending scoreboard bit
    idle(); li = 1; lw = 5'd9; step();
    idle(); jf = 1; ja = 32'h100; step();
    do_reset();
    idle(); step();

    // Single redirect
    idle(); jf = 1; ja = 32'h80; step();
    idle(); step(); step(); step(); step();

    // Interrupt wins over jump
    idle(); jf = 1; ja = 32'h40; ia = 1; iaddr = 32'h8; step();
    idle(); step(); step(); step(); step();

    // Second jump during FLUSH extends it
    idle(); jf = 1; ja = 32'h200; step();
    idle(); jf = 1; ja = 32'h300; step();
    idle(); repeat (5) step();

    // RAW on rs2 = x5, cleared by writeback
    idle(); li = 1; lw = 5'd5; step();
    idle(); r2e = 1; a2 = 5'd5; step(); step();
    idle(); r2e = 1; a2 = 5'd5; ld = 1; dw = 5'd5; step();
    idle(); r2e = 1; a2 = 5'd5; step();
    idle(); step();

    // x0 never becomes pending
    idle(); li = 1; lw = 5'd0; step();
    idle(); r1e = 1; r2e = 1; step();

    // Simultaneous set/clear
    idle(); li = 1; lw = 5'd4; step();
    idle(); li = 1; lw = 5'd7; ld = 1; dw = 5'd7; step();
    idle(); li = 1; lw = 5'd3; ld = 1; dw = 5'd4; step();
    idle(); ld = 1; dw = 5'd12; step();

    // Level merge
    idle(); rib = 1; step();
    idle(); rib = 1; ex = 1; step();
    idle(); jtag = 1; step();

    // Watchdog: 3 + gap + 3 stays clear, then a long run trips it
    raw_cycles(3);
    idle(); step();
    raw_cycles(3);
    idle(); step();
    raw_cycles(6);
    idle(); ld = 1; dw = 5'd7; step();
    idle(); r1e = 1; a1 = 5'd7; step(); step();

    // Randomized traffic
    do_reset();
    for (int unsigned n = 0; n < 3000; n++) begin
      idle();
      jf    = ($urandom_range(0, 15) == 0);
      ja    = $urandom;
      ia    = ($urandom_range(0, 31) == 0);
      iaddr = $urandom;
      ex    = ($urandom_range(0, 7) == 0);
      rib   = ($urandom_range(0, 7) == 0);
      jtag  = ($urandom_range(0, 15) == 0);
      r1e   = $urandom_range(0, 1) != 0;
      r2e   = $urandom_range(0, 1) != 0;
      a1    = 5'($urandom_range(0, 7));
      a2    = 5'($urandom_range(0, 7));
      li    = ($urandom_range(0, 3) == 0);
      lw    = 5'($urandom_range(0, 7));
      ld    = ($urandom_range(0, 3) == 0);
      dw    = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
